apex7_slot_encoder: RTL and testbench
=====================================

Name: apex7_slot_encoder

Overview:
- Initiator-side companion to the apex7 select decoder and transfer counter.
- Each cycle it watches six channel request lines and picks one with a round-robin arbiter.
- It encodes the chosen channel onto the 3-bit select bus {sel[2]=bit11, sel[1]=bit10, sel[0]=bit09} that the decoder turns into one-hot strobes, using a valid/ready handshake.
- It keeps the 7-bit transfer counter the decoder compares against its terminal pattern, and flags terminal count.

Parameters:
- CNT_W, 7: transfer counter width in bits.
- TERM_COUNT, 82: counter value that raises tc. 82 = bit pattern 1010010, LSB first = bit42..bit48 pattern 0100101.
- HOLD_ON_TC, 1: 1 = stop issuing at terminal count until tc_clr; 0 = keep running and let the counter wrap.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  6  per-channel request, level-sensitive; req[i] for channel i.
- ready  in  1  decoder side accepts the current select this cycle.
- tc_clr  in  1  clears tc and leaves HALT.
- sel  out  3  encoded channel select; 000 when idle.
- valid  out  1  sel holds a live transfer.
- chan  out  3  binary index of the granted channel (debug/scoreboard).
- count  out  CNT_W  number of accepted transfers, modulo 2^CNT_W.
- tc  out  1  terminal-count flag, sticky.

Behaviour:
- Reset (async, while asserted): sel=000, valid=0, chan=0, count=0, tc=0, rr_ptr=0, state=IDLE.
- Select encoding, fixed:
  - ch0 -> 010, ch1 -> 011 (sel[2]=0, sel[1]=1, sel[0]=channel LSB);
  - ch2 -> 100, ch3 -> 101, ch4 -> 110, ch5 -> 111 (sel[2]=1, {sel[1],sel[0]} = channel-2);
  - 000 and 001 never driven while valid=1.
- All outputs are registered. No combinational path from req/ready to any output.
- IDLE:
  - If any req bit is set, choose the first set bit at or after rr_ptr, scanning upward and wrapping 5->0.
  - Register sel/chan, set valid=1, go to ISSUE. Grant is visible one cycle after req is sampled.
- ISSUE:
  - While valid=1 and ready=0: hold sel, chan, valid stable. A later drop of req does not withdraw the transfer.
  - On valid & ready (accept edge):
    - count <= count+1, wrapping 2^CNT_W-1 -> 0;
    - rr_ptr <= (chan+1) mod 6.
  - After the accept, if the new count == TERM_COUNT: set tc=1. If HOLD_ON_TC=1, clear valid and sel=000 and go to HALT.
  - Otherwise, if any req is set (sampled in the same accept cycle, arbitrated from the updated pointer), issue back-to-back with valid staying 1 and new sel/chan. This gives one transfer per cycle when ready is held high.
  - Otherwise, if no req is set: valid=0, sel=000, go to IDLE.
- HALT:
  - valid=0, sel=000. Requests are ignored.
  - tc_clr: tc<=0 and go to IDLE. count is not cleared.
- tc_clr outside HALT clears tc only. If tc_clr and a terminal-count accept fall in the same cycle, the set wins (tc=1).
- HOLD_ON_TC=0: tc sets on reaching TERM_COUNT, no HALT, counter wraps freely. tc stays set until tc_clr.
- ready while valid=0 is ignored and count does not change.
- Reset asserted mid-transfer drops valid at once (async). The in-flight transfer is lost and not counted.

Test Plan:
- Reset/idle: hold reset 3 cycles, req=000000 -> sel=000, valid=0, count=0, tc=0; stays there 10 cycles after release.
- Single request: req=000100 (ch2), ready=0 for 4 cycles then 1 -> valid rises 1 cycle after req; sel=100 and chan=2 held stable through the stall; count=1 after accept; valid drops when req clears.
- Round-robin fairness: req=100001, ready=1 continuously -> grants alternate ch0(010), ch5(111), ch0, ch5 with no idle cycles; count increments every cycle.
- Encoding sweep: one request per channel 0..5 in turn -> sel = 010, 011, 100, 101, 110, 111.
- Terminal count, HOLD_ON_TC=1: req=111111, ready=1 -> on the 82nd accept tc=1, count=82, valid=0, no further grants; pulse tc_clr -> tc=0, issuing resumes, count=83.
- Wrap/async reset: HOLD_ON_TC=0, 128 accepts -> count returns to 0 and tc stays 1. Assert reset mid-stall with valid=1 -> valid=0 in the same cycle and count=0.

Source files
------------

// File: rtl/apex7_slot_encoder.sv
// Round-robin six-channel arbiter that encodes the granted channel onto the
// apex7 select bus under a valid/ready handshake and counts accepted transfers.
module apex7_slot_encoder #(
    parameter int CNT_W      = 7,
    parameter int TERM_COUNT = 82,
    parameter int HOLD_ON_TC = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       req,
    input  logic             ready,
    input  logic             tc_clr,
    output logic [2:0]       sel,
    output logic             valid,
    output logic [2:0]       chan,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TERM_V  = CNT_W'(TERM_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [2:0]       chan_q, chan_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;

    logic [CNT_W-1:0] cnt_inc_s;
    logic [2:0]       ptr_inc_s;
    logic [3:0]       pick_idle_s;
    logic [3:0]       pick_next_s;
    logic             term_hit_s;

    // First set request at or after ptr, wrapping 5->0; bit 3 flags a hit.
    function automatic logic [3:0] rr_pick(input logic [5:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [3:0] tmp;
        res = 4'b0000;
        for (int k = 5; k >= 0; k--) begin
            tmp = {1'b0, p} + 4'(k);
            if (tmp >= 4'd6) begin
                tmp = tmp - 4'd6;
            end else begin
                tmp = tmp;
            end
            if (r[tmp[2:0]]) begin
                res = {1'b1, tmp[2:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] sel_enc(input logic [2:0] ch);
        logic [2:0] s;
        case (ch)
            3'd0:    s = 3'b010;
            3'd1:    s = 3'b011;
            3'd2:    s = 3'b100;
            3'd3:    s = 3'b101;
            3'd4:    s = 3'b110;
            3'd5:    s = 3'b111;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    assign cnt_inc_s   = count_q + CNT_ONE;
    assign ptr_inc_s   = (chan_q == 3'd5) ? 3'd0 : (chan_q + 3'd1);
    assign pick_idle_s = rr_pick(req, rr_ptr_q);
    assign pick_next_s = rr_pick(req, ptr_inc_s);
    assign term_hit_s  = (cnt_inc_s == TERM_V);

    // Next-state logic for the arbiter FSM, counter and terminal flag.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        chan_d   = chan_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        tc_d     = tc_q & ~tc_clr;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle_s[3]) begin
                    valid_d = 1'b1;
                    chan_d  = pick_idle_s[2:0];
                    sel_d   = sel_enc(pick_idle_s[2:0]);
                    state_d = ST_ISSUE;
                end else begin
                    valid_d = 1'b0;
                    sel_d   = 3'b000;
                end
            end
            ST_ISSUE: begin
                if (valid_q && ready) begin
                    count_d  = cnt_inc_s;
                    rr_ptr_d = ptr_inc_s;
                    // A terminal-count set outranks a same-cycle tc_clr.
                    tc_d     = term_hit_s ? 1'b1 : (tc_q & ~tc_clr);
                    if (term_hit_s && (HOLD_ON_TC != 0)) begin
                        valid_d = 1'b0;
                        sel_d   = 3'b000;
                        state_d = ST_HALT;
                    end else if (pick_next_s[3]) begin
                        valid_d = 1'b1;
                        chan_d  = pick_next_s[2:0];
                        sel_d   = sel_enc(pick_next_s[2:0]);
                        state_d = ST_ISSUE;
                    end else begin
                        valid_d = 1'b0;
                        sel_d   = 3'b000;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
                sel_d   = 3'b000;
                if (tc_clr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                valid_d = 1'b0;
                sel_d   = 3'b000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 3'b000;
            valid_q  <= 1'b0;
            chan_q   <= 3'd0;
            count_q  <= '0;
            tc_q     <= 1'b0;
            rr_ptr_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            chan_q   <= chan_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign sel   = sel_q;
    assign valid = valid_q;
    assign chan  = chan_q;
    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_apex7_slot_encoder.sv
// Bench for apex7_slot_encoder: instance 0 halts at terminal count, instance 1
// wraps; both are compared each cycle against a behavioural transfer model.
module tb_apex7_slot_encoder;

    logic       clock;
    logic       rst     [2];
    logic [5:0] req     [2];
    logic       ready   [2];
    logic       tc_clr  [2];
    logic [2:0] sel_o   [2];
    logic       valid_o [2];
    logic [2:0] chan_o  [2];
    logic [6:0] count_o [2];
    logic       tc_o    [2];

    int checks;
    int failures;

    bit m_valid [2];
    int m_chan  [2];
    int m_count [2];
    bit m_tc    [2];
    bit m_halt  [2];
    int m_ptr   [2];

    apex7_slot_encoder #(.CNT_W(7), .TERM_COUNT(82), .HOLD_ON_TC(1)) u_hold (
        .clock(clock), .reset(rst[0]), .req(req[0]), .ready(ready[0]), .tc_clr(tc_clr[0]),
        .sel(sel_o[0]), .valid(valid_o[0]), .chan(chan_o[0]), .count(count_o[0]), .tc(tc_o[0])
    );

    apex7_slot_encoder #(.CNT_W(7), .TERM_COUNT(82), .HOLD_ON_TC(0)) u_wrap (
        .clock(clock), .reset(rst[1]), .req(req[1]), .ready(ready[1]), .tc_clr(tc_clr[1]),
        .sel(sel_o[1]), .valid(valid_o[1]), .chan(chan_o[1]), .count(count_o[1]), .tc(tc_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int pick(input logic [5:0] r, input int p);
        for (int k = 0; k < 6; k++) begin
            if (r[(p + k) % 6]) return (p + k) % 6;
        end
        return -1;
    endfunction

    function automatic void model_reset(input int d);
        m_valid[d] = 1'b0;
        m_chan[d]  = 0;
        m_count[d] = 0;
        m_tc[d]    = 1'b0;
        m_halt[d]  = 1'b0;
        m_ptr[d]   = 0;
    endfunction

    // One clock of the transfer rules for instance d (d==0 halts at terminal count).
    function automatic void model_step(input int d);
        int g;
        if (rst[d]) begin
            model_reset(d);
            return;
        end
        if (tc_clr[d]) m_tc[d] = 1'b0;
        if (m_halt[d]) begin
            if (tc_clr[d]) m_halt[d] = 1'b0;
            return;
        end
        if (m_valid[d]) begin
            if (!ready[d]) return;
            m_count[d] = (m_count[d] + 1) % 128;
            m_ptr[d]   = (m_chan[d] + 1) % 6;
            if (m_count[d] == 82) begin
                m_tc[d] = 1'b1;
                if (d == 0) begin
                    m_valid[d] = 1'b0;
                    m_halt[d]  = 1'b1;
                    return;
                end
            end
        end
        g = pick(req[d], m_ptr[d]);
        if (g >= 0) begin
            m_valid[d] = 1'b1;
            m_chan[d]  = g;
        end else begin
            m_valid[d] = 1'b0;
        end
    endfunction

    // Expected {valid, sel, count, tc}; sel is simply channel+2 while valid.
    function automatic logic [11:0] exp_vec(input int d);
        return {m_valid[d], (m_valid[d] ? 3'(m_chan[d] + 2) : 3'b000), 7'(m_count[d]), m_tc[d]};
    endfunction

    task automatic step();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 6'b0; ready[d] = 1'b0; tc_clr[d] = 1'b0;
            model_reset(d);
        end
        for (int c = 0; c < 13; c++) begin
            if (c == 3) begin
                rst[0] = 1'b0;
                rst[1] = 1'b0;
            end
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({valid_o[d], sel_o[d], count_o[d], tc_o[d]} !== 12'h000) begin
                    failures++;
                    $display("FAIL reset_idle d%0d c%0d got=%h want=000", d, c,
                             {valid_o[d], sel_o[d], count_o[d], tc_o[d]});
                end
            end
        end
    endtask

    task automatic test_single();
        req[0] = 6'b000100; ready[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req[0] = 6'b000000;
            step();
            checks++;
            if ({valid_o[0], sel_o[0], chan_o[0]} !== {1'b1, 3'b100, 3'd2} ||
                {valid_o[0], sel_o[0], count_o[0], tc_o[0]} !== exp_vec(0)) begin
                failures++;
                $display("FAIL single_stall c%0d got v=%0b sel=%b chan=%0d want v=1 sel=100 chan=2",
                         c, valid_o[0], sel_o[0], chan_o[0]);
            end
        end
        ready[0] = 1'b1;
        step();
        checks++;
        if (count_o[0] !== 7'd1 || valid_o[0] !== 1'b0 || sel_o[0] !== 3'b000) begin
            failures++;
            $display("FAIL single_accept got cnt=%0d v=%0b sel=%b want cnt=1 v=0 sel=000",
                     count_o[0], valid_o[0], sel_o[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] prev;
        req[0] = 6'b100001; ready[0] = 1'b1;
        prev = 3'b000;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if ({valid_o[0], sel_o[0], count_o[0], tc_o[0]} !== exp_vec(0) ||
                (c > 0 && sel_o[0] === prev)) begin
                failures++;
                $display("FAIL round_robin c%0d got=%h want=%h prev_sel=%b", c,
                         {valid_o[0], sel_o[0], count_o[0], tc_o[0]}, exp_vec(0), prev);
            end
            prev = sel_o[0];
        end
        req[0] = 6'b0;
        step();
    endtask

    task automatic test_encoding();
        for (int ch = 0; ch < 6; ch++) begin
            req[0] = 6'(1 << ch); ready[0] = 1'b0;
            step();
            checks++;
            if (sel_o[0] !== 3'(ch + 2) || chan_o[0] !== 3'(ch) || valid_o[0] !== 1'b1) begin
                failures++;
                $display("FAIL encode ch%0d got sel=%b chan=%0d v=%0b want sel=%b", ch,
                         sel_o[0], chan_o[0], valid_o[0], 3'(ch + 2));
            end
            req[0] = 6'b0; ready[0] = 1'b1;
            step();
        end
    endtask

    task automatic test_terminal();
        int budget;
        rst[0] = 1'b1; req[0] = 6'b0; tc_clr[0] = 1'b0;
        step();
        rst[0] = 1'b0; req[0] = 6'b111111; ready[0] = 1'b1;
        budget = 0;
        do begin
            step();
            budget++;
            checks++;
            if ({valid_o[0], sel_o[0], count_o[0], tc_o[0]} !== exp_vec(0)) begin
                failures++;
                $display("FAIL tc_run c%0d got=%h want=%h", budget,
                         {valid_o[0], sel_o[0], count_o[0], tc_o[0]}, exp_vec(0));
            end
        end while (!m_halt[0] && budget < 200);
        checks++;
        if (count_o[0] !== 7'd82 || tc_o[0] !== 1'b1 || valid_o[0] !== 1'b0 || budget != 83) begin
            failures++;
            $display("FAIL tc_halt got cnt=%0d tc=%0b v=%0b cycles=%0d want cnt=82 tc=1 v=0 cycles=83",
                     count_o[0], tc_o[0], valid_o[0], budget);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (valid_o[0] !== 1'b0 || sel_o[0] !== 3'b000 || tc_o[0] !== 1'b1) begin
                failures++;
                $display("FAIL tc_hold c%0d got v=%0b sel=%b tc=%0b want v=0 sel=000 tc=1",
                         c, valid_o[0], sel_o[0], tc_o[0]);
            end
        end
        tc_clr[0] = 1'b1;
        step();
        tc_clr[0] = 1'b0;
        checks++;
        if (tc_o[0] !== 1'b0 || valid_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL tc_clear got tc=%0b v=%0b want tc=0 v=0", tc_o[0], valid_o[0]);
        end
        step();
        step();
        checks++;
        if (count_o[0] !== 7'd83 || {valid_o[0], sel_o[0], count_o[0], tc_o[0]} !== exp_vec(0)) begin
            failures++;
            $display("FAIL tc_resume got cnt=%0d want 83", count_o[0]);
        end
        req[0] = 6'b0;
        step();
    endtask

    task automatic test_wrap_reset();
        rst[1] = 1'b1; req[1] = 6'b0; tc_clr[1] = 1'b0;
        step();
        rst[1] = 1'b0; req[1] = 6'b111111; ready[1] = 1'b1;
        for (int c = 0; c < 129; c++) begin
            step();
            checks++;
            if ({valid_o[1], sel_o[1], count_o[1], tc_o[1]} !== exp_vec(1)) begin
                failures++;
                $display("FAIL wrap_run c%0d got=%h want=%h", c,
                         {valid_o[1], sel_o[1], count_o[1], tc_o[1]}, exp_vec(1));
            end
        end
        checks++;
        if (count_o[1] !== 7'd0 || tc_o[1] !== 1'b1 || valid_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_zero got cnt=%0d tc=%0b v=%0b want cnt=0 tc=1 v=1",
                     count_o[1], tc_o[1], valid_o[1]);
        end
        ready[1] = 1'b0;
        step();
        rst[1] = 1'b1;
        model_reset(1);
        #1;
        checks++;
        if (valid_o[1] !== 1'b0 || count_o[1] !== 7'd0 || tc_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got v=%0b cnt=%0d tc=%0b want v=0 cnt=0 tc=0",
                     valid_o[1], count_o[1], tc_o[1]);
        end
        step();
        rst[1] = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                req[d]    = 6'($urandom);
                ready[d]  = ($urandom_range(0, 3) != 0);
                tc_clr[d] = ($urandom_range(0, 15) == 0);
            end
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({valid_o[d], sel_o[d], count_o[d], tc_o[d]} !== exp_vec(d) ||
                    (m_valid[d] && chan_o[d] !== 3'(m_chan[d]))) begin
                    failures++;
                    $display("FAIL random d%0d c%0d got=%h chan=%0d want=%h chan=%0d", d, c,
                             {valid_o[d], sel_o[d], count_o[d], tc_o[d]}, chan_o[d],
                             exp_vec(d), m_chan[d]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_encoding();
        test_terminal();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
